// File: rtl/mem1_dreq.sv
// First memory stage: size decode, alignment check, single DCache request per
// memory instruction, forwarding tap and the registered next-stage buffer.
module mem1_dreq #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clear,
    input  logic                  advance,
    output logic                  advance_ready,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic                  in_excp,
    input  logic                  in_load,
    input  logic                  in_store,
    input  logic [1:0]            in_size,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_sdata,
    input  logic                  in_wreg,
    input  logic [4:0]            in_waddr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic                  dreq_valid,
    output logic [ADDR_WIDTH-1:0] dreq_addr,
    output logic                  dreq_we,
    output logic [3:0]            dreq_wstrb,
    output logic [DATA_WIDTH-1:0] dreq_wdata,
    input  logic                  dreq_addr_ok,
    output logic                  fwd_wreg,
    output logic                  fwd_ready,
    output logic [4:0]            fwd_waddr,
    output logic [DATA_WIDTH-1:0] fwd_wdata,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_excp,
    output logic                  o_ale,
    output logic [ADDR_WIDTH-1:0] o_badv,
    output logic                  o_load,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [1:0]            o_size,
    output logic                  o_wreg,
    output logic [4:0]            o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC} state_t;

    state_t state, state_nx;
    logic   size_half, size_word, ale, mem_op;
    logic   [3:0] strb;

    assign size_half = (in_size == 2'd1);
    assign size_word = in_size[1];

    assign ale = in_valid & (in_load | in_store) &
                 ((size_half & in_addr[0]) | (size_word & (in_addr[1:0] != 2'b00)));
    assign mem_op = in_valid & ~in_excp & ~ale & (in_load | in_store);

    always_comb begin
        strb       = 4'b1111;
        dreq_wdata = in_sdata;
        case (in_size)
            2'd0: begin
                strb       = 4'b0001 << in_addr[1:0];
                dreq_wdata = {4{in_sdata[7:0]}};
            end
            2'd1: begin
                strb       = 4'b0011 << in_addr[1:0];
                dreq_wdata = {2{in_sdata[15:0]}};
            end
            default: begin
                strb       = 4'b1111;
                dreq_wdata = in_sdata;
            end
        endcase
    end

    assign dreq_addr  = {in_addr[ADDR_WIDTH-1:2], 2'b00};
    assign dreq_we    = in_store;
    assign dreq_wstrb = (in_store & ~in_load) ? strb : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // A flush drops the request unless the cache already accepted it this cycle,
    // so valid/addr_ok never disagree on the handshake.
    always_comb begin
        state_nx      = state;
        dreq_valid    = rst & mem_op & (state != S_ACC) & (~flush | dreq_addr_ok);
        advance_ready = rst & (~mem_op | (state == S_ACC) | dreq_addr_ok);
        case (state)
            S_IDLE:  if (mem_op) state_nx = dreq_addr_ok ? S_ACC : S_WAIT;
            S_WAIT:  if (dreq_addr_ok) state_nx = S_ACC;
            S_ACC:   state_nx = S_ACC;
            default: state_nx = S_IDLE;
        endcase
        if (flush | advance) state_nx = S_IDLE;
    end

    assign fwd_wreg  = in_valid & in_wreg;
    assign fwd_ready = in_valid & ~(in_load & mem_op);
    assign fwd_waddr = in_valid ? in_waddr : 5'd0;
    assign fwd_wdata = in_valid ? in_wdata : '0;

    always_ff @(posedge clk) begin
        if (!rst || flush || clear) begin
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_excp     <= 1'b0;
            o_ale      <= 1'b0;
            o_badv     <= '0;
            o_load     <= 1'b0;
            o_mem_addr <= '0;
            o_size     <= 2'd0;
            o_wreg     <= 1'b0;
            o_waddr    <= 5'd0;
            o_wdata    <= '0;
        end else if (advance) begin
            o_valid    <= in_valid;
            o_pc       <= in_pc;
            o_excp     <= in_excp | ale;
            o_ale      <= ale;
            o_badv     <= ale ? in_addr : '0;
            o_load     <= in_load & mem_op;
            o_mem_addr <= in_addr;
            o_size     <= in_size;
            o_wreg     <= in_wreg;
            o_waddr    <= in_waddr;
            o_wdata    <= in_wdata;
        end
    end

endmodule

// File: tb/tb_mem1_dreq.sv
// Directed bench for mem1_dreq: handshake, strobes, alignment, flush/clear/reset.
module tb_mem1_dreq;

    logic        clk = 1'b0;
    logic        rst, flush, clear, advance, advance_ready;
    logic        in_valid, in_excp, in_load, in_store, in_wreg;
    logic [31:0] in_pc, in_addr, in_sdata, in_wdata;
    logic [1:0]  in_size;
    logic [4:0]  in_waddr;
    logic        dreq_valid, dreq_we, dreq_addr_ok;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_wstrb;
    logic        fwd_wreg, fwd_ready;
    logic [4:0]  fwd_waddr;
    logic [31:0] fwd_wdata;
    logic        o_valid, o_excp, o_ale, o_load, o_wreg;
    logic [31:0] o_pc, o_badv, o_mem_addr, o_wdata;
    logic [1:0]  o_size;
    logic [4:0]  o_waddr;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned accepted;

    always #5 clk = ~clk;

    mem1_dreq #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .clear(clear), .advance(advance),
        .advance_ready(advance_ready), .in_valid(in_valid), .in_pc(in_pc),
        .in_excp(in_excp), .in_load(in_load), .in_store(in_store), .in_size(in_size),
        .in_addr(in_addr), .in_sdata(in_sdata), .in_wreg(in_wreg), .in_waddr(in_waddr),
        .in_wdata(in_wdata), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_we(dreq_we), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
        .dreq_addr_ok(dreq_addr_ok), .fwd_wreg(fwd_wreg), .fwd_ready(fwd_ready),
        .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .o_valid(o_valid), .o_pc(o_pc),
        .o_excp(o_excp), .o_ale(o_ale), .o_badv(o_badv), .o_load(o_load),
        .o_mem_addr(o_mem_addr), .o_size(o_size), .o_wreg(o_wreg), .o_waddr(o_waddr),
        .o_wdata(o_wdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs settle before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_excp = 0; in_load = 0; in_store = 0; in_size = 2'd0;
        in_pc = '0; in_addr = '0; in_sdata = '0; in_wreg = 0; in_waddr = '0; in_wdata = '0;
        flush = 0; clear = 0; advance = 0; dreq_addr_ok = 0;
    endtask

    task automatic op(input logic ld, input logic st, input logic [1:0] sz,
                      input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] sd);
        in_valid = 1; in_excp = 0; in_load = ld; in_store = st; in_size = sz;
        in_pc = pc; in_addr = addr; in_sdata = sd;
        in_wreg = ld; in_waddr = ld ? 5'd4 : 5'd0; in_wdata = addr;
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        tick(); tick();
        check("rst_dreq_valid", {31'd0, dreq_valid}, 32'd0);
        check("rst_adv_ready", {31'd0, advance_ready}, 32'd0);
        check("rst_o_valid", {31'd0, o_valid}, 32'd0);
        check("rst_fwd", {fwd_wreg, fwd_ready, fwd_waddr, 25'd0}, 32'd0);
        rst = 1;
        tick();

        // ld.w 0x1000, accepted at once
        op(1, 0, 2'd2, 32'h100, 32'h1000, 32'h0);
        dreq_addr_ok = 1; advance = 1;
        #1;
        check("ldw_valid", {31'd0, dreq_valid}, 32'd1);
        check("ldw_wstrb", {28'd0, dreq_wstrb}, 32'd0);
        check("ldw_addr", dreq_addr, 32'h1000);
        check("ldw_adv_ready", {31'd0, advance_ready}, 32'd1);
        check("ldw_fwd_ready", {31'd0, fwd_ready}, 32'd0);
        tick();
        check("ldw_o_load", {31'd0, o_load}, 32'd1);
        check("ldw_o_mem_addr", o_mem_addr, 32'h1000);
        check("ldw_o_pc", o_pc, 32'h100);
        check("ldw_o_badv", o_badv, 32'h0);

        // st.b 0xAB at 0x2003, addr_ok after 3 cycles
        op(0, 1, 2'd0, 32'h104, 32'h2003, 32'h0000_00AB);
        dreq_addr_ok = 0; advance = 0; accepted = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stb_valid", {31'd0, dreq_valid}, 32'd1);
            check("stb_wstrb", {28'd0, dreq_wstrb}, 32'h8);
            check("stb_wdata", dreq_wdata, 32'hABAB_ABAB);
            check("stb_addr", dreq_addr, 32'h2000);
            check("stb_adv_ready", {31'd0, advance_ready}, 32'd0);
            if (dreq_valid && dreq_addr_ok) accepted++;
            tick();
        end
        dreq_addr_ok = 1; advance = 1;
        #1;
        check("stb_ok_valid", {31'd0, dreq_valid}, 32'd1);
        check("stb_ok_we", {31'd0, dreq_we}, 32'd1);
        check("stb_ok_adv_ready", {31'd0, advance_ready}, 32'd1);
        if (dreq_valid && dreq_addr_ok) accepted++;
        tick();
        check("stb_accepted", accepted, 32'd1);
        check("stb_o_load", {31'd0, o_load}, 32'd0);
        check("stb_o_mem_addr", o_mem_addr, 32'h2003);

        // ld.h misaligned at 0x3001
        op(1, 0, 2'd1, 32'h108, 32'h3001, 32'h0);
        dreq_addr_ok = 0; advance = 1;
        #1;
        check("ale_valid", {31'd0, dreq_valid}, 32'd0);
        check("ale_adv_ready", {31'd0, advance_ready}, 32'd1);
        tick();
        check("ale_o_ale", {31'd0, o_ale}, 32'd1);
        check("ale_o_excp", {31'd0, o_excp}, 32'd1);
        check("ale_o_badv", o_badv, 32'h3001);
        check("ale_o_load", {31'd0, o_load}, 32'd0);

        // st.w with upstream exception never reaches the cache
        op(0, 1, 2'd2, 32'h10C, 32'h9000, 32'h1);
        in_excp = 1;
        #1;
        check("excp_valid", {31'd0, dreq_valid}, 32'd0);
        tick();
        check("excp_o_excp", {31'd0, o_excp}, 32'd1);
        check("excp_o_ale", {31'd0, o_ale}, 32'd0);

        // st.h at 0x4002 enters WAIT, then flushed
        op(0, 1, 2'd1, 32'h110, 32'h4002, 32'h0000_1234);
        advance = 0;
        #1;
        check("sth_wstrb", {28'd0, dreq_wstrb}, 32'hC);
        check("sth_wdata", dreq_wdata, 32'h1234_1234);
        tick();
        flush = 1;
        #1;
        check("flush_valid", {31'd0, dreq_valid}, 32'd0);
        tick();
        flush = 0; in_valid = 0;
        #1;
        check("flush_o_valid", {31'd0, o_valid}, 32'd0);
        check("flush_idle_valid", {31'd0, dreq_valid}, 32'd0);

        // ALU op passes through forwarding and fills the buffer
        idle_inputs();
        in_valid = 1; in_pc = 32'h114; in_wreg = 1; in_waddr = 5'd7; in_wdata = 32'hDEAD;
        advance = 1;
        #1;
        check("alu_fwd", {fwd_wreg, fwd_ready, fwd_waddr, 25'd0}, {1'b1, 1'b1, 5'd7, 25'd0});
        check("alu_fwd_wdata", fwd_wdata, 32'hDEAD);
        check("alu_dreq_valid", {31'd0, dreq_valid}, 32'd0);
        tick();
        check("alu_o_wdata", o_wdata, 32'hDEAD);
        check("alu_o_waddr", {27'd0, o_waddr}, 32'd7);

        // ld.w accepted, advance held low: no second request
        op(1, 0, 2'd2, 32'h118, 32'h5000, 32'h0);
        dreq_addr_ok = 1; advance = 0;
        #1;
        check("acc_first_valid", {31'd0, dreq_valid}, 32'd1);
        tick();
        dreq_addr_ok = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("acc_valid", {31'd0, dreq_valid}, 32'd0);
            check("acc_fwd_ready", {31'd0, fwd_ready}, 32'd0);
            check("acc_adv_ready", {31'd0, advance_ready}, 32'd1);
            check("acc_o_valid_hold", {31'd0, o_valid}, 32'd1);
            tick();
        end
        clear = 1; advance = 1;
        tick();
        clear = 0; advance = 0; in_valid = 0;
        check("clr_o_valid", {31'd0, o_valid}, 32'd0);
        check("clr_o_wdata", o_wdata, 32'h0);
        check("clr_o_mem_addr", o_mem_addr, 32'h0);

        // st.w in WAIT, then reset with advance still high
        op(0, 1, 2'd2, 32'h11C, 32'h7000, 32'h5555_AAAA);
        tick();
        rst = 0; advance = 1;
        #1;
        check("rstw_valid", {31'd0, dreq_valid}, 32'd0);
        tick();
        check("rstw_o_valid", {31'd0, o_valid}, 32'd0);
        check("rstw_o_pc", o_pc, 32'h0);
        rst = 1; in_valid = 0; advance = 0;
        #1;
        check("rstw_idle_valid", {31'd0, dreq_valid}, 32'd0);
        tick();

        // ld.b after reset issues normally
        op(1, 0, 2'd0, 32'h120, 32'h8002, 32'h0);
        dreq_addr_ok = 1; advance = 1;
        #1;
        check("ldb_valid", {31'd0, dreq_valid}, 32'd1);
        check("ldb_addr", dreq_addr, 32'h8000);
        check("ldb_wstrb", {28'd0, dreq_wstrb}, 32'd0);
        tick();
        check("ldb_o_load", {31'd0, o_load}, 32'd1);
        check("ldb_o_mem_addr", o_mem_addr, 32'h8002);
        check("ldb_o_size", {30'd0, o_size}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem1_dreq.md
Name: mem1_dreq

Overview:
- First memory stage. Sits between EXE and the load-return stage, which consumes its registered output.
- Decodes load/store size and checks alignment. Issues exactly one DCache request per memory instruction via a valid/addr_ok handshake, then holds until the pipeline advances.
- Registers the instruction into the next-stage buffer and provides a forwarding tap for dispatch.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, register/data width (fixed at 32 for strobe logic)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
flush  in  1  kill current instruction and buffer
clear  in  1  bubble: zero the output buffer only
advance  in  1  pipeline moves this cycle
advance_ready  out  1  stage may advance
in_valid  in  1  instruction valid from EXE
in_pc  in  ADDR_WIDTH  instruction PC
in_excp  in  1  upstream exception already raised
in_load  in  1  memory load
in_store  in  1  memory store
in_size  in  2  0=byte, 1=half, 2=word (3 illegal, treated as word)
in_addr  in  ADDR_WIDTH  effective address
in_sdata  in  DATA_WIDTH  store data, low-aligned
in_wreg  in  1  register write enable
in_waddr  in  5  destination register
in_wdata  in  DATA_WIDTH  ALU result
dreq_valid  out  1  DCache request valid
dreq_addr  out  ADDR_WIDTH  request address (word-aligned)
dreq_we  out  1  1=store
dreq_wstrb  out  4  byte strobes
dreq_wdata  out  DATA_WIDTH  lane-shifted store data
dreq_addr_ok  in  1  DCache accepted request this cycle
fwd_wreg  out  1  forward: write enable
fwd_ready  out  1  forward: data valid now
fwd_waddr  out  5  forward: register
fwd_wdata  out  DATA_WIDTH  forward: data
o_valid  out  1  registered: instruction valid
o_pc  out  ADDR_WIDTH  registered PC
o_excp  out  1  registered exception (in_excp | ale)
o_ale  out  1  registered alignment-error flag
o_badv  out  ADDR_WIDTH  registered bad address (in_addr on ALE, else 0)
o_load  out  1  registered load flag, cleared when a request was not issued
o_mem_addr  out  ADDR_WIDTH  registered full address
o_size  out  2  registered size
o_wreg  out  1  registered write enable
o_waddr  out  5  registered destination
o_wdata  out  DATA_WIDTH  registered ALU result

Behaviour:
- ale = in_valid & (in_load|in_store) & ((size==1 & addr[0]) | (size>=2 & addr[1:0]!=0)).
- mem_op = in_valid & ~in_excp & ~ale & (in_load|in_store).
- Strobe generation:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<addr[1:0].
  - word: 4'b1111.
  - Loads drive wstrb=0.
- wdata lanes:
  - byte: sdata[7:0] replicated ×4.
  - half: sdata[15:0] replicated ×2.
  - word: sdata unchanged.
- dreq_addr = {addr[ADDR_WIDTH-1:2],2'b00}.
- FSM, state register reset to IDLE:
  - IDLE: mem_op=1 → dreq_valid=1 combinationally.
    - addr_ok same cycle → ACC.
    - addr_ok=0 → WAIT.
  - WAIT: dreq_valid=1, request fields stable. addr_ok → ACC.
  - ACC: dreq_valid=0. No second request for the same instruction.
  - Leave to IDLE on advance or flush from any state.
  - flush has priority over addr_ok. The request is dropped (dreq_valid=0) in the flush cycle, except that an addr_ok already returned in that cycle counts as issued, and the instruction is still killed.
- advance_ready = ~mem_op | (state==ACC) | ((state!=ACC) & dreq_addr_ok).
- dreq_valid is never asserted when in_excp, ale, or ~in_valid. An exception therefore never reaches DCache.
- Forwarding:
  - Non-load: {in_wreg, 1, in_waddr, in_wdata}.
  - Load with mem_op: {in_wreg, 0, in_waddr, in_wdata}.
  - in_valid=0: all zero.
- Output buffer priority: rst low → all o_* = 0; else flush|clear → 0; else advance → capture inputs. o_excp = in_excp|ale; o_load = in_load & mem_op.
- Reset mid-WAIT: FSM to IDLE, dreq_valid=0 the next cycle, no outstanding state kept.
- Every output resets to 0. dreq_* and fwd_* are combinational and follow inputs while in IDLE with in_valid=0.

Test Plan:
- ld.w at addr 0x1000, addr_ok high immediately → dreq_valid=1, wstrb=0, dreq_addr=0x1000, advance_ready=1 same cycle; after advance o_load=1, o_mem_addr=0x1000.
- st.b of sdata=0xAB at 0x2003, addr_ok delayed 3 cycles → dreq_valid held 3 cycles with wstrb=4'b1000, wdata=0xABABABAB; advance_ready=0 until the addr_ok cycle; exactly one accepted request.
- ld.h at 0x3001 → no dreq_valid; advance_ready=1; after advance o_ale=1, o_excp=1, o_badv=0x3001, o_load=0.
- st.h at 0x4002 in WAIT, flush asserted without addr_ok → dreq_valid=0 that cycle; next cycle FSM IDLE; o_valid=0.
- ld.w accepted (ACC), advance held low 2 cycles → dreq_valid stays 0, fwd_ready=0, advance_ready=1; then clear+advance → o_* all 0.
- rst=0 during WAIT → next cycle dreq_valid=0, all o_* 0, FSM IDLE; a new ld.b after reset release issues normally.
